// File: rtl/ddr4_cmd_sequencer.sv
// ddr4_cmd_sequencer
//
// Turns one READ, WRITE or ROWCLONE request at a time into a DDR4 command
// sequence (ACT -> RD/WR -> PRE, or ACT -> ACT -> PRE for a row clone) on the
// command/address pins. It also generates the data-phase strobes that tell the
// datapath when to drive dq/dqs (writes) or to expect read data.
//
// Ports
//   clk        : clock, everything updates on the rising edge
//   rst        : synchronous active-high reset, returns to idle with pins deselected
//   req_valid  : a request is presented
//   req_ready  : sequencer is idle and accepts the request this cycle
//   req_type   : 0 READ, 1 WRITE, 2 ROWCLONE, 3 reserved (retired as a no-op)
//   req_rank   : target rank index
//   req_bg     : target bank group
//   req_ba     : target bank
//   req_row    : row to open (source row for ROWCLONE)
//   req_row2   : destination row for ROWCLONE
//   req_col    : column for READ/WRITE
//   cs_n       : per-rank chip select, active low
//   act_n      : activate strobe, active low
//   A          : address / command bus (upper three bits are RAS_n/CAS_n/WE_n when act_n=1)
//   bg, ba     : bank group / bank pins
//   dq_oe      : controller drives dq/dqs this cycle (write beat)
//   rd_valid   : a read beat is expected on dq this cycle
//   beat       : beat index within the current burst, 0 outside bursts
//   done       : one-cycle pulse when the request has fully retired
module ddr4_cmd_sequencer #(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int tRCD      = 15,
    parameter int tCL       = 15,
    parameter int tCWL      = 0,
    parameter int tRAS      = 32,
    parameter int tRP       = 15,
    localparam int RANKW    = (RANKS > 1) ? $clog2(RANKS) : 1,
    localparam int BEATW    = (BL > 1) ? $clog2(BL) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_type,
    input  logic [RANKW-1:0]     req_rank,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [ADDRWIDTH-1:0] req_row2,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic [RANKS-1:0]     cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 dq_oe,
    output logic                 rd_valid,
    output logic [BEATW-1:0]     beat,
    output logic                 done
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_ACT  = 4'd1;
    localparam logic [3:0] S_TRCD = 4'd2;
    localparam logic [3:0] S_CAS  = 4'd3;
    localparam logic [3:0] S_DATA = 4'd4;
    localparam logic [3:0] S_ACT2 = 4'd5;
    localparam logic [3:0] S_TRAS = 4'd6;
    localparam logic [3:0] S_PRE  = 4'd7;
    localparam logic [3:0] S_TRP  = 4'd8;
    localparam logic [3:0] S_DONE = 4'd9;

    localparam logic [1:0] T_READ     = 2'd0;
    localparam logic [1:0] T_WRITE    = 2'd1;
    localparam logic [1:0] T_ROWCLONE = 2'd2;
    localparam logic [1:0] T_RESERVED = 2'd3;

    // Counter preloads. The "-2" preloads account for the cycle spent in the
    // command state itself plus the cycle in which the counter reads zero.
    localparam logic [7:0] TRCD_M2 = 8'(tRCD - 2);
    localparam logic [7:0] TRP_M2  = 8'(tRP - 2);
    localparam logic [7:0] TRAS_M1 = 8'(tRAS - 1);
    localparam logic [7:0] TCL8    = 8'(tCL);
    localparam logic [7:0] TCWL8   = 8'(tCWL);
    localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(BL - 1);

    logic [3:0]           state;
    logic [1:0]           type_q;
    logic [RANKW-1:0]     rank_q;
    logic [BGWIDTH-1:0]   bg_q;
    logic [BAWIDTH-1:0]   ba_q;
    logic [ADDRWIDTH-1:0] row_q;
    logic [ADDRWIDTH-1:0] row2_q;
    logic [COLWIDTH-1:0]  col_q;
    logic [7:0]           wait_cnt;
    logic [7:0]           tras_cnt;
    logic [BEATW-1:0]     beat_cnt;
    logic                 act2_done;

    logic [7:0]           data_lat;
    logic                 tras_ready_next;
    logic                 data_strobe;
    logic [RANKS-1:0]     cmd_cs_n;

    assign req_ready = (state == S_IDLE) && !rst;
    assign data_lat  = (type_q == T_WRITE) ? TCWL8 : TCL8;

    // tras_cnt reaches zero exactly tRAS cycles after the last ACT, so a value
    // of one or less means the next cycle is allowed to carry PRE (or ACT2).
    assign tras_ready_next = (tras_cnt <= 8'd1);

    // With zero latency the first beat coincides with the CAS cycle, so the
    // strobe must also be raised while still in S_CAS.
    assign data_strobe = ((state == S_DATA) && (wait_cnt == 8'd0)) ||
                         ((state == S_CAS) && (data_lat == 8'd0));

    assign cmd_cs_n = ~(RANKS'(1) << rank_q);

    // Sequencing FSM plus its phase counter, tRAS counter and beat counter.
    // tRAS counts down freely and saturates at zero; every ACT reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            type_q    <= T_READ;
            rank_q    <= '0;
            bg_q      <= '0;
            ba_q      <= '0;
            row_q     <= '0;
            row2_q    <= '0;
            col_q     <= '0;
            wait_cnt  <= 8'd0;
            tras_cnt  <= 8'd0;
            beat_cnt  <= '0;
            act2_done <= 1'b0;
        end else begin
            if (tras_cnt != 8'd0) begin
                tras_cnt <= tras_cnt - 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        type_q    <= req_type;
                        rank_q    <= req_rank;
                        bg_q      <= req_bg;
                        ba_q      <= req_ba;
                        row_q     <= req_row;
                        row2_q    <= req_row2;
                        col_q     <= req_col;
                        act2_done <= 1'b0;
                        state     <= (req_type == T_RESERVED) ? S_DONE : S_ACT;
                    end
                end
                S_ACT: begin
                    tras_cnt <= TRAS_M1;
                    if (type_q == T_ROWCLONE) begin
                        state <= (tRAS <= 1) ? S_ACT2 : S_TRAS;
                    end else if (tRCD <= 1) begin
                        state <= S_CAS;
                    end else begin
                        wait_cnt <= TRCD_M2;
                        state    <= S_TRCD;
                    end
                end
                S_TRCD: begin
                    if (wait_cnt == 8'd0) begin
                        state <= S_CAS;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_CAS: begin
                    beat_cnt <= '0;
                    if (data_lat == 8'd0) begin
                        if (BL == 1) begin
                            state <= tras_ready_next ? S_PRE : S_TRAS;
                        end else begin
                            beat_cnt <= BEATW'(1);
                            wait_cnt <= 8'd0;
                            state    <= S_DATA;
                        end
                    end else begin
                        wait_cnt <= data_lat - 8'd1;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else if (beat_cnt == LAST_BEAT) begin
                        beat_cnt <= '0;
                        state    <= tras_ready_next ? S_PRE : S_TRAS;
                    end else begin
                        beat_cnt <= beat_cnt + BEATW'(1);
                    end
                end
                S_TRAS: begin
                    if (tras_ready_next) begin
                        state <= ((type_q == T_ROWCLONE) && !act2_done) ? S_ACT2 : S_PRE;
                    end
                end
                S_ACT2: begin
                    tras_cnt  <= TRAS_M1;
                    act2_done <= 1'b1;
                    state     <= (tRAS <= 1) ? S_PRE : S_TRAS;
                end
                S_PRE: begin
                    if (tRP <= 1) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= TRP_M2;
                        state    <= S_TRP;
                    end
                end
                S_TRP: begin
                    if (wait_cnt == 8'd0) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pin decode. Every cycle that is not a command cycle is a deselect with
    // the address/bank pins parked at zero.
    always_comb begin
        cs_n     = '1;
        act_n    = 1'b1;
        A        = '0;
        bg       = '0;
        ba       = '0;
        dq_oe    = 1'b0;
        rd_valid = 1'b0;
        beat     = '0;
        done     = 1'b0;

        case (state)
            S_ACT, S_ACT2: begin
                cs_n  = cmd_cs_n;
                act_n = 1'b0;
                A     = (state == S_ACT) ? row_q : row2_q;
                bg    = bg_q;
                ba    = ba_q;
            end
            S_CAS: begin
                cs_n                = cmd_cs_n;
                A[COLWIDTH-1:0]     = col_q;
                A[10]               = 1'b0;
                A[ADDRWIDTH-1]      = 1'b1;
                A[ADDRWIDTH-2]      = 1'b0;
                A[ADDRWIDTH-3]      = (type_q == T_READ);
                bg                  = bg_q;
                ba                  = ba_q;
            end
            S_PRE: begin
                cs_n           = cmd_cs_n;
                A[ADDRWIDTH-2] = 1'b1;
                bg             = bg_q;
                ba             = ba_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase

        if (data_strobe) begin
            dq_oe    = (type_q == T_WRITE);
            rd_valid = (type_q == T_READ);
            beat     = (state == S_DATA) ? beat_cnt : '0;
        end
    end

endmodule
